mem_port_arbiter: RTL

- Shares one single-port synchronous main memory between the processor's instruction-fetch requester (IF) and its data-access requester (D, from the MEM stage).
- Sits between pipelineProcessor and a single-port memory_main variant.
- Grants one requester per cycle and stalls the loser. Routes the memory read data back to the owner with a valid pulse.
- Bounds IF starvation with a data-streak counter.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_streak_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: owner-state encoding and
// default data/address widths.
package mem_arb_pkg;

    localparam int DW = 20;
    localparam int AW = 5;

    typedef logic [1:0] owner_t;

    localparam owner_t IDLE    = 2'd0;
    localparam owner_t RESP_IF = 2'd1;
    localparam owner_t RESP_D  = 2'd2;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// Clear wins over increment; at_max_o flags the saturation value.
module arb_streak_counter #(
    parameter int MAX = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        at_max_o = (cnt_q == W'(MAX));
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data access; data has priority, bounded by a streak counter.
module mem_port_arbiter #(
    parameter int DW          = mem_arb_pkg::DW,
    parameter int AW          = mem_arb_pkg::AW,
    parameter int MAX_DSTREAK = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_stall,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_stall,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    input  logic [DW-1:0] m_q
);

    import mem_arb_pkg::*;

    logic          grant_d, grant_if, at_max;
    logic          streak_inc, streak_clr;
    owner_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
        grant_d  = ~Reset & d_req & ~(if_req & at_max);
        grant_if = ~Reset & if_req & ~grant_d;
        if_stall = if_req & ~grant_if;
        d_stall  = d_req & ~grant_d;

        m_addr  = '0;
        m_wdata = '0;
        m_we    = 1'b0;
        if (grant_d) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
        end else if (grant_if) begin
            m_addr = if_addr;
        end
    end

    // IF is waiting whenever if_req is high; a break in its request resets fairness.
    assign streak_inc = grant_d & if_req;
    assign streak_clr = grant_if | ~if_req;

    arb_streak_counter #(
        .MAX (MAX_DSTREAK)
    ) u_streak (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .inc_i    (streak_inc),
        .clr_i    (streak_clr),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d = IDLE;
        if (grant_d) begin
            state_d = RESP_D;
        end else if (grant_if) begin
            state_d = RESP_IF;
        end
        wr_d = grant_d ? d_we : wr_q;
    end

    // Memory data arrives the cycle after the grant, so it is forwarded
    // straight through while valid and captured to hold afterwards.
    always_comb begin
        if_valid   = ~Reset & (state_q == RESP_IF);
        d_valid    = ~Reset & (state_q == RESP_D);
        if_rdata_d = if_valid ? m_q : if_rdata_q;
        d_rdata_d  = (d_valid && !wr_q) ? m_q : d_rdata_q;
        if_rdata   = if_rdata_d;
        d_rdata    = d_rdata_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule
